// File: rtl/ram_bus_arbiter_if.sv
// Master handshakes and RAM control signals shared by the two-master RAM arbiter.
// The slave modport is the arbiter's view; master is the view of the CPU/DMA/RAM side.
interface ram_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_re;
    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output ram_addr, ram_we, ram_re, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  ram_addr, ram_we, ram_re, busy
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters, one access at a time.
// Sequence per access: IDLE (grant + latch) -> ISSUE (ISSUE_CYCLES) -> ACK (one-cycle pulse).
module ram_bus_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int ISSUE_CYCLES = 1    // legal 1..15
) (
    input  logic                clk,
    input  logic                rst,
    ram_bus_arbiter_if.slave    bus,
    inout  wire  [DATA_W-1:0]   ram_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ISSUE_CYCLES - 1);

    state_t            state, state_nxt;
    logic              grant, grant_nxt, last_grant;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [3:0]        cnt;

    logic              we_o, re_o, ack0_o, ack1_o;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign sel_we    = grant_nxt ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = grant_nxt ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = grant_nxt ? bus.m1_wdata : bus.m0_wdata;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
        state_nxt = state;
        grant_nxt = last_grant;
        we_o      = 1'b0;
        re_o      = 1'b0;
        ack0_o    = 1'b0;
        ack1_o    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_nxt = ISSUE;
                    // A tie goes to whoever did not win last time.
                    grant_nxt = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
                end
            end
            ISSUE: begin
                we_o = lat_we;
                re_o = ~lat_we;
                if (cnt == 4'd0) state_nxt = ACK;
            end
            ACK: begin
                ack0_o    = ~grant;
                ack1_o    = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            // NOTE: the latched request copy is reset too because lat_addr is what ram_addr shows out of reset.
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= 4'd0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees the pre-edge values.
            state <= state_nxt;
            if (state == IDLE && state_nxt == ISSUE) begin
                grant      <= grant_nxt;
                last_grant <= grant_nxt;
                lat_we     <= sel_we;
                lat_addr   <= sel_addr;
                lat_wdata  <= sel_wdata;
                cnt        <= CNT_LOAD;
            end
            if (state == ISSUE) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (!lat_we) begin
                    // Final ISSUE edge of a read: capture the RAM output for the granted master.
                    if (grant) rdata1 <= ram_data;
                    else       rdata0 <= ram_data;
                end
            end
        end
    end

    assign bus.ram_addr = lat_addr;
    assign bus.ram_we   = we_o;
    assign bus.ram_re   = re_o;
    assign bus.m0_ack   = ack0_o;
    assign bus.m1_ack   = ack1_o;
    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;
    assign bus.busy     = (state != IDLE);

    // The data bus is driven only while a write is in ISSUE; it follows state, so reset releases it at once.
    assign ram_data = we_o ? lat_wdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: cycle-level access model checked every cycle, plus directed cases
// (write/read, tie alternation, long ISSUE, reset mid-write, back-to-back request, random two-master run).
module tb_ram_bus_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int IC  = 1;
    localparam int IC3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
    ram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();
    wire [DW-1:0] ram_data;
    wire [DW-1:0] ram_data3;

    ram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ISSUE_CYCLES(IC)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ram_data(ram_data)
    );
    ram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ISSUE_CYCLES(IC3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .ram_data(ram_data3)
    );

    // RAMs behind each arbiter: combinational read, write on the clock edge.
    logic [DW-1:0] ram  [256];
    logic [DW-1:0] ram3 [256];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    pullup (ram_data);
    assign ram_data  = bus.ram_re  ? ram[bus.ram_addr]   : 'z;
    assign ram_data3 = bus3.ram_re ? ram3[bus3.ram_addr] : 'z;

    always @(posedge clk) begin
        if (bus.ram_we)  ram[bus.ram_addr]   <= ram_data;
        if (bus3.ram_we) ram3[bus3.ram_addr] <= ram_data3;
        if (pre_en) begin
            ram[pre_addr]  <= pre_data;
            ram3[pre_addr] <= pre_data;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, got, want, $time);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Access model: an access granted at edge s is in ISSUE for cycles s..s+IC-1, acks in cycle s+IC,
    // and the arbiter looks at requests again on the edge that ends cycle s+IC+1.
    logic [DW-1:0] exp_mem [256];
    logic [DW-1:0] exp_rdata [2];
    logic          m_act  = 1'b0;
    logic          m_last = 1'b1;
    logic          m_g    = 1'b0;
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd   = '0;
    int            m_start = 0;
    int            ph;
    logic          in_issue, in_ack;

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst) begin
                m_act        = 1'b0;
                m_last       = 1'b1;
                exp_rdata[0] = '0;
                exp_rdata[1] = '0;
                check("rst_busy", bus.busy, 1'b0);
                check("rst_ram_we", bus.ram_we, 1'b0);
            end else begin
                ph       = cyc - m_start;
                in_issue = m_act && (ph < IC);
                in_ack   = m_act && (ph == IC);
                check("ram_we", bus.ram_we, in_issue && m_we);
                check("ram_re", bus.ram_re, in_issue && !m_we);
                check("busy", bus.busy, m_act);
                check("m0_ack", bus.m0_ack, in_ack && !m_g);
                check("m1_ack", bus.m1_ack, in_ack && m_g);
                check("we_re_overlap", bus.ram_we && bus.ram_re, 1'b0);
                check("double_ack", bus.m0_ack && bus.m1_ack, 1'b0);
                check("m0_rdata", bus.m0_rdata, exp_rdata[0]);
                check("m1_rdata", bus.m1_rdata, exp_rdata[1]);
                if (in_issue) check("ram_addr", bus.ram_addr, m_addr);
                if (in_issue && m_we)  check("ram_data_write", ram_data, m_wd);
                else if (in_issue)     check("ram_data_read", ram_data, exp_mem[m_addr]);
                else                   check("ram_data_released", ram_data, 8'hFF);

                if (m_act) begin
                    if (ph == IC - 1) begin
                        if (m_we) exp_mem[m_addr] = m_wd;
                        else      exp_rdata[m_g] = exp_mem[m_addr];
                    end
                    if (ph == IC) m_act = 1'b0;
                end else if (bus.m0_req || bus.m1_req) begin
                    if (bus.m0_req && bus.m1_req) m_g = !m_last;
                    else                          m_g = bus.m1_req;
                    m_last  = m_g;
                    m_act   = 1'b1;
                    m_start = cyc + 1;
                    m_we    = m_g ? bus.m1_we    : bus.m0_we;
                    m_addr  = m_g ? bus.m1_addr  : bus.m0_addr;
                    m_wd    = m_g ? bus.m1_wdata : bus.m0_wdata;
                end
            end
        end
    end

    logic req_q [2];

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end
        req_q[m] = req;
    endtask

    task automatic drive_random(input int m);
        drive(m, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    endtask

    function automatic logic ack_of(input int m);
        return (m == 0) ? bus.m0_ack : bus.m1_ack;
    endfunction

    // Edges counted from the request being raised until its ack is visible; -1 if the bound expires.
    task automatic wait_ack(input int m, input int limit, output int delay);
        delay = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (ack_of(m)) begin
                delay = i;
                break;
            end
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(posedge clk); #1;
        pre_en     = 1'b0;
        exp_mem[a] = d;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int d, n, n0, nre, nacks, guard, t0;
        int ack_m [4];
        int ack_t [4];

        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        bus3.m0_req = 1'b0; bus3.m0_we = 1'b0; bus3.m0_addr = '0; bus3.m0_wdata = '0;
        bus3.m1_req = 1'b0; bus3.m1_we = 1'b0; bus3.m1_addr = '0; bus3.m1_wdata = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_ram_addr", bus.ram_addr, 8'h00);
        check("reset_ram_we", bus.ram_we, 1'b0);
        check("reset_ram_re", bus.ram_re, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_acks", {bus.m0_ack, bus.m1_ack}, 2'b00);
        check("reset_rdata", {bus.m0_rdata, bus.m1_rdata}, 16'h0000);
        check("reset_ram_data_z", ram_data, 8'hFF);
        check("reset_busy_ic3", bus3.busy, 1'b0);

        for (int a = 0; a < 256; a++) preload(8'(a), 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write then read by m0.
        drive(0, 1'b1, 1'b1, 8'h05, 8'hA7);
        wait_ack(0, 10, d);
        check("t1_write_latency", d, 2);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
        wait_ack(0, 10, d);
        check("t1_read_latency", d, 2);
        check("t1_rdata", bus.m0_rdata, 8'hA7);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;

        // Request held past ack with a new address becomes the next access.
        drive(0, 1'b1, 1'b1, 8'h10, 8'h55);
        wait_ack(0, 10, d);
        check("t6_first_latency", d, 2);
        drive(0, 1'b1, 1'b1, 8'h20, 8'h66);
        wait_ack(0, 10, d);
        check("t6_back_to_back_latency", d, 3);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        check("t6_ram_first", ram[8'h10], 8'h55);
        check("t6_ram_second", ram[8'h20], 8'h66);

        // Reset in the ISSUE cycle of a write.
        preload(8'h02, 8'h11);
        drive(0, 1'b1, 1'b1, 8'h02, 8'hFF);
        @(posedge clk); #1;
        check("t4_in_issue", bus.ram_we, 1'b1);
        rst = 1'b1;
        #1;
        check("t4_rst_we_drop", bus.ram_we, 1'b0);
        check("t4_rst_busy", bus.busy, 1'b0);
        check("t4_rst_addr", bus.ram_addr, 8'h00);
        check("t4_rst_data_z", ram_data, 8'hFF);
        drive(0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n0 = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.m0_ack) n0++;
        end
        check("t4_no_ack", n0, 0);
        check("t4_ram_kept", ram[8'h02], 8'h11);

        // Both masters requesting straight out of reset.
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h02, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        t0 = cyc;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(posedge clk); #1;
            if (bus.m0_ack || bus.m1_ack) begin
                ack_m[n] = bus.m1_ack ? 1 : 0;
                ack_t[n] = cyc;
                n++;
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        check("t2_ack_count", n, 4);
        if (n == 4) begin
            check("t2_first_latency", ack_t[0] - t0, 2);
            for (int i = 0; i < 4; i++) check("t2_grant_order", ack_m[i], i % 2);
            for (int i = 1; i < 4; i++) check("t2_ack_spacing", ack_t[i] - ack_t[i-1], 3);
        end
        repeat (2) @(posedge clk);
        #1;

        // Random two-master traffic.
        nacks = 0;
        guard = 0;
        while (nacks < 500 && guard < 8000) begin
            @(posedge clk); #1;
            guard++;
            for (int m = 0; m < 2; m++) begin
                if (req_q[m]) begin
                    if (ack_of(m)) begin
                        nacks++;
                        if ($urandom_range(0, 3) == 0) drive(m, 1'b0, 1'b0, '0, '0);
                        else                           drive_random(m);
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    drive_random(m);
                end
            end
        end
        check("t5_accesses_done", nacks >= 500, 1'b1);
        guard = 0;
        while ((req_q[0] || req_q[1]) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
            for (int m = 0; m < 2; m++)
                if (req_q[m] && ack_of(m)) drive(m, 1'b0, 1'b0, '0, '0);
        end
        check("t5_drained", req_q[0] || req_q[1], 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Three-cycle ISSUE read by m1 on the second arbiter.
        preload(8'h0F, 8'h3C);
        bus3.m1_req = 1'b1; bus3.m1_we = 1'b0; bus3.m1_addr = 8'h0F;
        nre = 0; n0 = 0; d = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus3.ram_re) nre++;
            if (bus3.m0_ack) n0++;
            if (bus3.m1_ack && d < 0) begin
                d = i;
                bus3.m1_req = 1'b0;
            end
        end
        check("t3_re_cycles", nre, 3);
        check("t3_latency", d, 4);
        check("t3_rdata", bus3.m1_rdata, 8'h3C);
        check("t3_no_m0_ack", n0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
